// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler for the five-stage pipeline.
// Accepts a mult/div/MTHI/MTLO operation from EX, computes the 64-bit result
// at acceptance, holds it for a fixed busy window, then commits it to HI/LO.
// Requests a front-end stall while a D-stage md instruction would see a
// pending result.
//
// Ports:
//   clk        clock, posedge
//   reset      synchronous, active-high reset
//   start      EX-stage operation valid
//   op[2:0]    0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD
//   a[31:0]    rs operand
//   b[31:0]    rt operand
//   md_use_d   D-stage instruction uses the md unit
//   busy       registered, operation in flight
//   hi[31:0]   registered HI
//   lo[31:0]   registered LO
//   stall_req  combinational stall request
//
// Build option: define MD_SCHED_MADD_EN to enable op 7 (MADD:
// {hi,lo} += signed(a)*signed(b), MULT_CYCLES latency). Undefined, op 7 is NONE.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_req
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_SCHED_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd7;
`endif

    localparam logic [3:0] LP_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      r_state, w_nxt_state;
    logic [3:0]  r_cnt, w_nxt_cnt;
    logic [63:0] r_res, w_nxt_res;
    logic        r_dz, w_nxt_dz;
    logic        r_busy, w_nxt_busy;
    logic [31:0] r_hi, w_nxt_hi;
    logic [31:0] r_lo, w_nxt_lo;

    // Arithmetic datapath (evaluated on the operands present at acceptance)
    logic signed [63:0] w_a_s, w_b_s, w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_is_div, w_is_sdiv, w_b_zero, w_long_op;
    logic [31:0] w_a_mag, w_b_mag, w_dvd, w_dvs, w_q_mag, w_r_mag, w_quo, w_rem;
    logic [63:0] w_op_res;

    assign w_a_s    = {{32{a[31]}}, a};
    assign w_b_s    = {{32{b[31]}}, b};
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    assign w_is_sdiv = (op == OP_DIV);
    assign w_is_div  = (op == OP_DIV) || (op == OP_DIVU);
    assign w_b_zero  = (b == '0);

    // Signed divide via magnitudes: avoids the 0x80000000 / -1 overflow case,
    // whose magnitude quotient 0x80000000 is already the wrapped result.
    assign w_a_mag = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag = b[31] ? (~b + 32'd1) : b;
    assign w_dvd   = w_is_sdiv ? w_a_mag : a;
    assign w_dvs   = w_b_zero ? 32'd1 : (w_is_sdiv ? w_b_mag : b);
    assign w_q_mag = w_dvd / w_dvs;
    assign w_r_mag = w_dvd % w_dvs;
    assign w_quo   = (w_is_sdiv && (a[31] ^ b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = (w_is_sdiv && a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

    always_comb begin
        w_long_op = 1'b0;
        w_op_res  = '0;
        case (op)
            OP_MULT:  begin w_long_op = 1'b1; w_op_res = w_prod_s;        end
            OP_MULTU: begin w_long_op = 1'b1; w_op_res = w_prod_u;        end
            OP_DIV:   begin w_long_op = 1'b1; w_op_res = {w_rem, w_quo};  end
            OP_DIVU:  begin w_long_op = 1'b1; w_op_res = {w_rem, w_quo};  end
`ifdef MD_SCHED_MADD_EN
            OP_MADD:  begin w_long_op = 1'b1; w_op_res = {r_hi, r_lo} + w_prod_s; end
`endif
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_res   <= '0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_res   <= w_nxt_res;
            r_dz    <= w_nxt_dz;
            r_busy  <= w_nxt_busy;
            r_hi    <= w_nxt_hi;
            r_lo    <= w_nxt_lo;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_res   = r_res;
        w_nxt_dz    = r_dz;
        w_nxt_busy  = r_busy;
        w_nxt_hi    = r_hi;
        w_nxt_lo    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start && w_long_op) begin
                    w_nxt_res   = w_op_res;
                    w_nxt_cnt   = w_is_div ? LP_DIV_N : LP_MULT_N;
                    w_nxt_dz    = w_is_div && w_b_zero;
                    w_nxt_busy  = 1'b1;
                    w_nxt_state = S_RUN;
                end else if (start && (op == OP_MTHI)) begin
                    w_nxt_hi = a;
                end else if (start && (op == OP_MTLO)) begin
                    w_nxt_lo = a;
                end
            end
            S_RUN: begin
                w_nxt_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_nxt_busy  = 1'b0;
                    w_nxt_state = S_IDLE;
                    // Divide by zero: window runs, HI/LO keep prior values
                    if (!r_dz) begin
                        w_nxt_hi = r_res[63:32];
                        w_nxt_lo = r_res[31:0];
                    end
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign stall_req = md_use_d && (r_busy || (start && w_long_op));

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: timeline-based model (busy ends at an absolute cycle,
// results computed with 64-bit integer arithmetic) compared on every negedge,
// plus directed literal expectations from hand arithmetic.
module tb_md_sched;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        md_use_d = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .busy(busy), .hi(hi), .lo(lo), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_long(input logic [2:0] o);
        bit r;
        r = (o >= 3'd1) && (o <= 3'd4);
`ifdef MD_SCHED_MADD_EN
        if (o == 3'd7) r = 1'b1;
`endif
        return r;
    endfunction

    // Model: cyc counts posedges; the unit is busy while cyc < m_end and the
    // pending result lands at the edge where cyc reaches m_end.
    int          cyc = 0;
    int          m_end = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;
    bit          m_pv = 1'b0;

    always @(posedge clk) begin : model
        longint sa, sb;
        longint unsigned ua, ub;
        cyc++;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_pv = 1'b0; m_end = cyc;
        end else begin
            if (cyc == m_end && m_pv) begin
                {m_hi, m_lo} = m_pend;
                m_pv = 1'b0;
            end
            if ((cyc - 1) >= m_end && start) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ua = {32'd0, a};
                ub = {32'd0, b};
                case (op)
                    3'd1: begin m_pend = sa * sb; m_pv = 1'b1; m_end = cyc + MC; end
                    3'd2: begin m_pend = ua * ub; m_pv = 1'b1; m_end = cyc + MC; end
                    3'd3: begin
                        m_end = cyc + DC;
                        m_pv = (b != 0);
                        if (b != 0) m_pend = {32'(sa % sb), 32'(sa / sb)};
                    end
                    3'd4: begin
                        m_end = cyc + DC;
                        m_pv = (b != 0);
                        if (b != 0) m_pend = {32'(ua % ub), 32'(ua / ub)};
                    end
                    3'd5: m_hi = a;
                    3'd6: m_lo = a;
`ifdef MD_SCHED_MADD_EN
                    3'd7: begin m_pend = {m_hi, m_lo} + 64'(sa * sb); m_pv = 1'b1; m_end = cyc + MC; end
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin : compare
        bit mb;
        if (chk_en) begin
            mb = (cyc < m_end);
            chk("busy", 32'(busy), 32'(mb));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("stall_req", 32'(stall_req), 32'(md_use_d && (mb || (start && is_long(op)))));
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
            @(posedge clk); #2;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        chk("idle_bound", 32'(busy), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;
        md_use_d = 1'b1;

        // MULT -2 * 3, stall asserted in the start cycle
        start = 1'b1; op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3;
        #1 chk("stall_start", 32'(stall_req), 32'd1);
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        count_busy(n);
        chk("mult_len", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        chk("stall_after", 32'(stall_req), 32'd0);

        // MULTU
        issue(3'd2, 32'hFFFFFFFF, 32'd2);
        wait_idle();
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        // DIV -7 / 2
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        count_busy(n);
        chk("div_len", 32'(n + 1), 32'd10 + 32'd1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        // DIV overflow case
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        chk("divov_lo", lo, 32'h80000000);
        chk("divov_hi", hi, 32'h00000000);

        // DIV 7 / -2, DIVU 100 / 7
        issue(3'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle();
        chk("divneg_lo", lo, 32'hFFFFFFFD);
        chk("divneg_hi", hi, 32'h00000001);
        issue(3'd4, 32'd100, 32'd7);
        wait_idle();
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // MTHI / MTLO then DIVU by zero keeps HI/LO
        issue(3'd5, 32'h12345678, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", 32'(busy), 32'd0);
        issue(3'd6, 32'h00000000, 32'd0);
        chk("mtlo_lo", lo, 32'd0);
        issue(3'd4, 32'd55, 32'd0);
        count_busy(n);
        chk("dz_len", 32'(n), 32'd10);
        chk("dz_hi", hi, 32'h12345678);
        chk("dz_lo", lo, 32'd0);

        // Back-to-back: new start in the first cycle busy reads 0
        issue(3'd1, 32'd7, 32'd6);
        n = 0;
        while (busy !== 1'b0 && n < 40) begin @(posedge clk); #2; n++; end
        chk("b2b_lo1", lo, 32'd42);
        issue(3'd2, 32'd3, 32'd5);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        chk("b2b_lo2", lo, 32'd15);
        chk("b2b_hi2", hi, 32'd0);

        // Starts during RUN are ignored
        issue(3'd1, 32'd2, 32'd3);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd3;
        idle(1);
        op = 3'd5; a = 32'hDEADBEEF;
        idle(1);
        start = 1'b0; op = 3'd0;
        wait_idle();
        chk("run_ign_lo", lo, 32'd6);
        chk("run_ign_hi", hi, 32'd0);
        idle(12);
        chk("run_ign_busy", 32'(busy), 32'd0);

        // Reset during busy cycle 3
        issue(3'd1, 32'd5, 32'd5);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rst3_busy", 32'(busy), 32'd0);
        chk("rst3_hi", hi, 32'd0);
        chk("rst3_lo", lo, 32'd0);
        idle(8);
        chk("rst3_lo_late", lo, 32'd0);

        // op 7
        issue(3'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MD_SCHED_MADD_EN
        issue(3'd7, 32'd1, 32'd1);
        wait_idle();
        chk("madd_hi", hi, 32'd1);
        chk("madd_lo", lo, 32'd0);
`else
        start = 1'b1; op = 3'd7; a = 32'd1; b = 32'd1;
        #1 chk("op7_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #2;
        start = 1'b0; op = 3'd0;
        chk("op7_busy", 32'(busy), 32'd0);
        chk("op7_hi", hi, 32'd0);
        chk("op7_lo", lo, 32'hFFFFFFFF);
`endif

        // NONE with start, and a MULT opcode without start: no effect
        issue(3'd0, 32'h55555555, 32'd9);
        start = 1'b0; op = 3'd1; a = 32'd9; b = 32'd9;
        idle(2);
        op = 3'd0;
        chk("none_busy", 32'(busy), 32'd0);

        // No stall without a D-stage md user
        md_use_d = 1'b0;
        issue(3'd2, 32'h10000, 32'h10000);
        chk("nouse_stall", 32'(stall_req), 32'd0);
        wait_idle();
        chk("nouse_hi", hi, 32'd1);
        chk("nouse_lo", lo, 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the five-stage pipeline.
- Accepts a mult/div/move-to-HI/LO operation from the EX stage and sequences a fixed-latency busy window.
- Owns the HI/LO registers, which feed the MDO value carried down to MEM/WB.
- Raises a stall request so the hazard logic freezes the front-end pipeline registers while a result is pending.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX-stage operation valid this cycle.
- op  input  3  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
- a  input  32  rs operand (forwarded value).
- b  input  32  rt operand (forwarded value).
- md_use_d  input  1  instruction in D stage is mult/div/mfhi/mflo/mthi/mtlo/madd.
- busy  output  1  registered; operation in flight.
- hi  output  32  registered HI.
- lo  output  32  registered LO.
- stall_req  output  1  combinational; equals md_use_d & (busy | (start & op in {1,2,3,4,7})).

Behaviour:
- Reset: state IDLE, busy=0, hi=0, lo=0, cnt=0, pending result discarded. Reset overrides start on the same edge.
- States: IDLE and RUN; 4-bit down-counter cnt; 64-bit pending result register res.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU/MADD:
  - Compute the result from a and b sampled at this edge; store it in res.
  - Load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN:
  - cnt decrements each cycle.
  - On the edge where cnt==1: {hi,lo} <= res, busy <= 0, go to IDLE.
  - busy is therefore high for exactly N cycles; new hi/lo are visible in the first cycle busy is low.
- IDLE, start=1, op=MTHI: hi <= a at the next edge; lo unchanged; busy stays 0.
- IDLE, start=1, op=MTLO: lo <= a at the next edge; hi unchanged; busy stays 0.
- op=NONE, or start=0: no state change.
- Start while RUN: ignored entirely. The pipeline guarantees this does not happen through stall_req; the bench checks that it is ignored.
- MULT: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
- MULTU: unsigned 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits.
- DIV (signed, truncates toward zero): lo = quotient, hi = remainder; the remainder takes the sign of the dividend.
- DIVU: unsigned; lo = quotient, hi = remainder.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- Divide by zero (b==0) for DIV/DIVU:
  - Full DIV_CYCLES busy window still runs.
  - At completion hi and lo keep their pre-operation values; res is not written into them.
- Back-to-back: start is accepted in the same cycle busy first reads 0; there is no dead cycle.
- hi/lo never change during RUN, so MFHI/MFLO issued after the stall always read completed values.

Optional Feature:
- Macro MD_SCHED_MADD_EN.
- Defined: op=7 (MADD) computes {hi,lo} + signed(a)*signed(b), modulo 2^64, and uses MULT_CYCLES latency. The {hi,lo} term is the value at acceptance.
- Undefined: op=7 is treated as NONE; no busy, no state change; stall_req excludes op 7.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678 then DIVU b=0 -> hi=0x12345678 and lo=0 unchanged after the 10-cycle busy window.
- MULT started; md_use_d=1 throughout -> stall_req=1 in the start cycle and for all 5 busy cycles, 0 after.
- Second start during RUN -> ignored.
- Reset asserted on busy cycle 3 -> next cycle busy=0, hi=lo=0.
- With MD_SCHED_MADD_EN defined: MADD with hi=0, lo=0xFFFFFFFF, a=1, b=1 -> hi=1, lo=0.
